// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the internal data bus transfer sequencer.
//   state_e    : transfer FSM state encoding (IDLE/DRIVE/LATCH/RELEASE)
//   SETTLE_MAX : largest supported settle interval in cycles
// -----------------------------------------------------------------------------
package bus_pkg;

  localparam int SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE   = 2'd1,
    ST_LATCH   = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

endpackage

// File: rtl/onehot_noe_decoder.sv
// -----------------------------------------------------------------------------
// onehot_noe_decoder
// Maps a driver index plus an enable to an active-low one-hot output-enable
// vector. An index outside 0..N-1, or a deasserted enable, yields all ones.
// Ports:
//   i_idx : driver index
//   i_en  : drive enable
//   o_noe : per-driver active-low output enable
// -----------------------------------------------------------------------------
module onehot_noe_decoder #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_en,
  output logic [N-1:0]     o_noe
);

  always_comb begin
    o_noe = '1;
    for (int i = 0; i < N; i++) begin
      if (i_en && (int'(i_idx) == i)) begin
        o_noe[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_transfer_ctrl.sv
// -----------------------------------------------------------------------------
// bus_transfer_ctrl
// Sequences one bus transfer at a time: enables a single source driver,
// waits SETTLE_CYCLES, strobes the destination loads while capturing the
// resolved bus value, then releases the bus for one cycle before idling.
//
// Optional feature macro: BUS_CHECK_EN
//   When defined, the resolved-net flag i_bus_noe is checked during LATCH;
//   a faulty net suppresses the load strobes and the capture, and sets the
//   sticky o_err flag. When undefined, i_bus_noe is ignored and o_err is 0.
//
// Ports:
//   i_clk, i_nrst          : clock, synchronous active-low reset
//   i_req_valid/o_req_ready: request handshake
//   i_req_src, i_req_dst   : source index and destination load mask
//   o_src_noe              : per-source active-low output enables
//   i_bus_data, i_bus_noe  : resolved bus value and net-fault flag
//   o_dst_load             : one-cycle destination load strobes
//   o_data                 : last captured bus value
//   o_done                 : one-cycle completion pulse
//   o_err                  : sticky bus-fault flag
// -----------------------------------------------------------------------------
module bus_transfer_ctrl
  import bus_pkg::*;
#(
  parameter int SOURCE_COUNT  = 4,
  parameter int DEST_COUNT    = 4,
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1,
  parameter int SRC_W         = (SOURCE_COUNT > 1) ? $clog2(SOURCE_COUNT) : 1
) (
  input  logic                    i_clk,
  input  logic                    i_nrst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [SRC_W-1:0]        i_req_src,
  input  logic [DEST_COUNT-1:0]   i_req_dst,
  output logic [SOURCE_COUNT-1:0] o_src_noe,
  input  logic [WIDTH-1:0]        i_bus_data,
  input  logic                    i_bus_noe,
  output logic [DEST_COUNT-1:0]   o_dst_load,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_done,
  output logic                    o_err
);

  localparam int CNT_W = $clog2(SETTLE_MAX + 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SRC_W-1:0]        src_q, src_d;
  logic [DEST_COUNT-1:0]   dst_q, dst_d;
  logic [SOURCE_COUNT-1:0] noe_q, noe_d;
  logic [DEST_COUNT-1:0]   load_q, load_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    ready_q, ready_d;
  logic                    bus_fault;
  logic                    drive_en;

`ifdef BUS_CHECK_EN
  assign bus_fault = i_bus_noe;
`else
  logic unused_bus_noe;
  assign unused_bus_noe = i_bus_noe;
  assign bus_fault      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    err_d   = err_q;
    load_d  = '0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // ready_q is high exactly in IDLE, so this is valid & ready.
        if (i_req_valid) begin
          state_d = ST_DRIVE;
          src_d   = i_req_src;
          dst_d   = i_req_dst;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end
      end
      ST_DRIVE: begin
        if (cnt_q == '0) begin
          state_d = ST_LATCH;
          load_d  = dst_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_LATCH: begin
        state_d = ST_RELEASE;
        done_d  = 1'b1;
        if (bus_fault) begin
          err_d = 1'b1;
        end else begin
          data_d = i_bus_data;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // The source stays enabled through LATCH; RELEASE and IDLE are all-high,
  // which gives break-before-make between consecutive transfers.
  assign drive_en = (state_d == ST_DRIVE) || (state_d == ST_LATCH);

  onehot_noe_decoder #(
    .N     (SOURCE_COUNT),
    .IDX_W (SRC_W)
  ) u_noe_dec (
    .i_idx (src_d),
    .i_en  (drive_en),
    .o_noe (noe_d)
  );

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      noe_q   <= '1;
      load_q  <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      noe_q   <= noe_d;
      load_q  <= load_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign o_req_ready = ready_q;
  assign o_src_noe   = noe_q;
  // load_q is only non-zero during LATCH, the cycle in which the net is judged.
  assign o_dst_load  = load_q & ~{DEST_COUNT{bus_fault}};
  assign o_data      = data_q;
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule
